// File: rtl/sum_stream_pkg.sv
// Shared widths, helpers and state encodings
// for the adder sum-stream consumers.
package sum_stream_pkg;

    localparam int SUM_W         = 9;
    localparam int FRAME_LEN_DEF = 16;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational saturating add of a sample onto
// an accumulator; returns {clip, result}.
module sat_add #(
    parameter int ACC_W  = 13,
    parameter int DATA_W = 9
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [DATA_W-1:0] i_data,
    output logic [ACC_W:0]    o_res
);

    localparam int SW = ((ACC_W > DATA_W) ? ACC_W : DATA_W) + 1;

    logic [SW-1:0] w_sum;
    logic          w_clip;

    // Wide add, then clamp to all-ones when any bit above ACC_W is set
    always_comb begin
        w_sum  = SW'(i_acc) + SW'(i_data);
        w_clip = |w_sum[SW-1:ACC_W];
        o_res  = {w_clip, w_clip ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0]};
    end

endmodule

// File: rtl/sum_frame_accum.sv
// Frame accumulator for the adder sum stream:
// per-frame total, peak, count and clip flag.
module sum_frame_accum
    import sum_stream_pkg::*;
#(
    parameter int DATA_W    = SUM_W,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int ACC_W     = DATA_W + clog2(FRAME_LEN),
    parameter int CNT_W     = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_total,
    output logic [DATA_W-1:0] out_max,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_sat
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ACC_W-1:0]    r_acc;
    logic [DATA_W-1:0]   r_max;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_sat;
    logic [ACC_W:0]      w_add;
    logic [DATA_W-1:0]   w_max_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_fire;
    logic                w_close;
    logic                w_take;

    // One adder serves both the running sum and the close path
    sat_add #(
        .ACC_W (ACC_W),
        .DATA_W(DATA_W)
    ) u_add (
        .i_acc (r_acc),
        .i_data(in_data),
        .o_res (w_add)
    );

    assign out_valid = (r_state == ST_HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign w_take    = out_valid && out_ready;
    assign w_fire    = in_valid && in_ready && !clear;
    assign w_close   = w_fire && ((r_cnt == LAST_IDX) || in_last);
    assign w_max_nxt = (in_data > r_max) ? in_data : r_max;
    assign w_cnt_nxt = r_cnt + CNT_W'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: enter HOLD on close, leave once taken without a new close
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_ACCUM: begin
                if (w_close) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_take && !w_close) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
        endcase
    end

    // Running frame state; clear and close both restart the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_max <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (clear || w_close) begin
            r_acc <= '0;
            r_max <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (w_fire) begin
            r_acc <= w_add[ACC_W-1:0];
            r_max <= w_max_nxt;
            r_cnt <= w_cnt_nxt;
            r_sat <= r_sat | w_add[ACC_W];
        end
    end

    // Result registers load only on a closing beat and otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_total <= '0;
            out_max   <= '0;
            out_cnt   <= '0;
            out_sat   <= 1'b0;
        end else if (w_close) begin
            out_total <= w_add[ACC_W-1:0];
            out_max   <= w_max_nxt;
            out_cnt   <= w_cnt_nxt;
            out_sat   <= r_sat | w_add[ACC_W];
        end
    end

endmodule

// File: tb/tb_sum_frame_accum.sv
// Randomised and directed bench for sum_frame_accum; two instances
// (ACC_W=13 and ACC_W=10) share stimulus and one frame-list model.
module tb_sum_frame_accum;

    localparam int FL    = 4;
    localparam int MAX_A = 8191;
    localparam int MAX_B = 1023;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_last;
    logic        clear;
    logic        out_ready;
    logic [8:0]  in_data;

    logic        rdy_a, rdy_b, v_a, v_b, sat_a, sat_b;
    logic [12:0] tot_a;
    logic [9:0]  tot_b;
    logic [8:0]  max_a, max_b, cnt_a, cnt_b;

    int n_checks = 0;
    int n_err    = 0;

    int q[$];
    bit e_valid;
    int e_tot_a, e_tot_b, e_max, e_cnt;
    bit e_sat_a, e_sat_b;

    sum_frame_accum #(
        .DATA_W(9), .FRAME_LEN(FL), .ACC_W(13), .CNT_W(9)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(rdy_a), .in_data(in_data), .in_last(in_last),
        .clear(clear), .out_valid(v_a), .out_ready(out_ready),
        .out_total(tot_a), .out_max(max_a), .out_cnt(cnt_a),
        .out_sat(sat_a)
    );

    sum_frame_accum #(
        .DATA_W(9), .FRAME_LEN(FL), .ACC_W(10), .CNT_W(9)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(rdy_b), .in_data(in_data), .in_last(in_last),
        .clear(clear), .out_valid(v_b), .out_ready(out_ready),
        .out_total(tot_b), .out_max(max_b), .out_cnt(cnt_b),
        .out_sat(sat_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        e_valid = 0;
    endtask

    // Frame-level model: samples collected in a list, results from plain sums
    task automatic model_step();
        bit rdy, take, closed;
        int sum, mx;
        rdy    = !e_valid || out_ready;
        take   = e_valid && out_ready;
        closed = 0;
        if (clear) begin
            q.delete();
        end else if (in_valid && rdy) begin
            q.push_back(int'(in_data));
            if (q.size() == FL || in_last) begin
                sum = 0;
                mx  = 0;
                foreach (q[i]) begin
                    sum += q[i];
                    if (q[i] > mx) mx = q[i];
                end
                e_cnt   = q.size();
                e_max   = mx;
                e_tot_a = (sum > MAX_A) ? MAX_A : sum;
                e_tot_b = (sum > MAX_B) ? MAX_B : sum;
                e_sat_a = sum > MAX_A;
                e_sat_b = sum > MAX_B;
                e_valid = 1;
                closed  = 1;
                q.delete();
            end
        end
        if (!closed && take) e_valid = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #2;
    endtask

    task automatic send(input int d, input bit last);
        in_valid = 1'b1;
        in_data  = 9'(d);
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", {31'd0, v_a}, 32'd0);
        chk("rst_in_ready", {31'd0, rdy_a}, 32'd1);
        chk("rst_total", {19'd0, tot_a}, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_a", {31'd0, rdy_a},
                {31'd0, (!e_valid || out_ready)});
            chk("in_ready_b", {31'd0, rdy_b},
                {31'd0, (!e_valid || out_ready)});
            chk("out_valid_a", {31'd0, v_a}, {31'd0, e_valid});
            chk("out_valid_b", {31'd0, v_b}, {31'd0, e_valid});
            if (e_valid) begin
                chk("total_a", {19'd0, tot_a}, e_tot_a);
                chk("total_b", {22'd0, tot_b}, e_tot_b);
                chk("max_a", {23'd0, max_a}, e_max);
                chk("max_b", {23'd0, max_b}, e_max);
                chk("cnt_a", {23'd0, cnt_a}, e_cnt);
                chk("cnt_b", {23'd0, cnt_b}, e_cnt);
                chk("sat_a", {31'd0, sat_a}, {31'd0, e_sat_a});
                chk("sat_b", {31'd0, sat_b}, {31'd0, e_sat_b});
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        model_reset();
        #3;
        chk("reset_valid", {31'd0, v_a}, 32'd0);
        chk("reset_ready", {31'd0, rdy_a}, 32'd1);
        chk("reset_total", {19'd0, tot_a}, 32'd0);
        chk("reset_cnt", {23'd0, cnt_a}, 32'd0);
        #9;
        rst_n = 1'b1;
        tick();

        // Plain frame of four
        send(8, 0); send(17, 0); send(256, 0); send(0, 0);
        chk("t1_valid", {31'd0, v_a}, 32'd1);
        chk("t1_total", {19'd0, tot_a}, 32'd281);
        chk("t1_max", {23'd0, max_a}, 32'd256);
        chk("t1_cnt", {23'd0, cnt_a}, 32'd4);
        chk("t1_sat", {31'd0, sat_a}, 32'd0);
        tick();

        // Early close, then single-beat frame
        send(8, 0); send(17, 1);
        chk("t2_total", {19'd0, tot_a}, 32'd25);
        chk("t2_max", {23'd0, max_a}, 32'd17);
        chk("t2_cnt", {23'd0, cnt_a}, 32'd2);
        send(5, 1);
        chk("t2b_valid", {31'd0, v_a}, 32'd1);
        chk("t2b_total", {19'd0, tot_a}, 32'd5);
        chk("t2b_cnt", {23'd0, cnt_a}, 32'd1);
        tick();

        // Backpressure while a result is pending
        out_ready = 1'b0;
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        in_valid = 1'b1;
        in_data  = 9'd100;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_stall", {31'd0, rdy_a}, 32'd0);
            chk("t3_hold", {19'd0, tot_a}, 32'd10);
        end
        out_ready = 1'b1;
        #1;
        chk("t3_release", {31'd0, rdy_a}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("t3_taken", {31'd0, v_a}, 32'd0);
        send(1, 0); send(1, 0); send(1, 0);
        chk("t3_total", {19'd0, tot_a}, 32'd103);
        chk("t3_max", {23'd0, max_a}, 32'd100);
        tick();

        // Saturation on the narrow instance
        send(511, 0); send(511, 0); send(511, 0); send(511, 0);
        chk("t4_total_b", {22'd0, tot_b}, 32'd1023);
        chk("t4_sat_b", {31'd0, sat_b}, 32'd1);
        chk("t4_max_b", {23'd0, max_b}, 32'd511);
        chk("t4_total_a", {19'd0, tot_a}, 32'd2044);
        chk("t4_sat_a", {31'd0, sat_a}, 32'd0);
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        chk("t4b_total_b", {22'd0, tot_b}, 32'd10);
        chk("t4b_sat_b", {31'd0, sat_b}, 32'd0);
        tick();

        // Reset mid-frame and in HOLD
        send(8, 0); send(17, 0);
        do_reset();
        out_ready = 1'b0;
        send(9, 0); send(9, 0); send(9, 0); send(9, 0);
        do_reset();
        out_ready = 1'b1;
        send(1, 0); send(1, 0); send(1, 0); send(1, 0);
        chk("t5_total", {19'd0, tot_a}, 32'd4);
        tick();

        // Clear drops the partial frame but not the pending result
        out_ready = 1'b0;
        send(8, 0); send(17, 0); send(256, 0); send(0, 0);
        tick();
        chk("t6_pending", {19'd0, tot_a}, 32'd281);
        out_ready = 1'b1;
        send(50, 0);
        chk("t6_taken", {31'd0, v_a}, 32'd0);
        send(60, 0);
        clear = 1'b1;
        send(200, 0);
        clear = 1'b0;
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        chk("t6_total", {19'd0, tot_a}, 32'd10);
        chk("t6_cnt", {23'd0, cnt_a}, 32'd4);
        tick();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = ($urandom_range(0, 3) == 0) ? 9'd511
                        : 9'($urandom_range(0, 511));
            in_last   = ($urandom_range(0, 7) == 0);
            clear     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        clear    = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
